// File: rtl/lisp_defs.sv
// Shared definitions: status/error codes plus the memory arbiter state
// encoding and its abort fill word.
package lisp_defs;

   localparam logic [7:0] LISP_ERR_NONE     = 8'h00;
   localparam logic [7:0] LISP_ERR_TYPE     = 8'h01;
   localparam logic [7:0] LISP_ERR_UNBOUND  = 8'h02;
   localparam logic [7:0] LISP_ERR_OVERFLOW = 8'h03;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RESPOND = 2'd3
   } arb_state_t;

   localparam logic [15:0] ARB_TIMEOUT_DATA = 16'hCCCC;
   localparam int          ARB_CNT_W        = 9;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
interface mem_arbiter_if;

   logic        req0;
   logic        req1;
   logic [11:0] addr0;
   logic [11:0] addr1;
   logic        gnt0;
   logic        gnt1;
   logic        ready0;
   logic        ready1;
   logic [15:0] data0;
   logic [15:0] data1;
   logic        mem_req;
   logic [11:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_data;

   // The arbiter side.
   modport slave (
      input  req0, req1, addr0, addr1, mem_ready, mem_data,
      output gnt0, gnt1, ready0, ready1, data0, data1, mem_req, mem_addr
   );

   // The requester/memory side that drives the arbiter.
   modport master (
      output req0, req1, addr0, addr1, mem_ready, mem_data,
      input  gnt0, gnt1, ready0, ready1, data0, data1, mem_req, mem_addr
   );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester read arbiter in front of a single memory port; one
// transaction at a time with a bounded wait and a sticky abort flag.
module mem_arbiter
   import lisp_defs::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          busy,
   output logic          timeout
);

   localparam logic [ARB_CNT_W-1:0] LP_TMO = ARB_CNT_W'(TIMEOUT_CYCLES);

   arb_state_t           r_state;
   arb_state_t           w_state_next;
   logic                 r_owner;
   logic                 r_last_owner;
   logic [11:0]          r_addr;
   logic [ARB_CNT_W-1:0] r_cnt;
   logic                 r_timeout;
   logic [15:0]          r_data0;
   logic [15:0]          r_data1;

   logic                 w_any_req;
   logic                 w_winner;
   logic [ARB_CNT_W-1:0] w_cnt_inc;
   logic                 w_tmo_hit;
   logic                 w_load;
   logic [15:0]          w_word;

   assign w_any_req = bus.req0 | bus.req1;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_tmo_hit = (w_cnt_inc == LP_TMO);

   // On a tie round-robin hands the memory to the port that did not own it last.
   always_comb begin
      w_winner = 1'b0;
      if (bus.req0 && bus.req1) begin
         w_winner = (FIXED_PRIORITY != 0) ? 1'b0 : ~r_last_owner;
      end else if (bus.req1) begin
         w_winner = 1'b1;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_any_req) w_state_next = ST_ISSUE;
         ST_ISSUE:   w_state_next = ST_WAIT;
         ST_WAIT:    if (bus.mem_ready || w_tmo_hit) w_state_next = ST_RESPOND;
         ST_RESPOND: w_state_next = ST_IDLE;
         default:    w_state_next = ST_IDLE;
      endcase
   end

   // A real completion wins over an abort landing in the same cycle.
   assign w_load = (r_state == ST_WAIT) && (bus.mem_ready || w_tmo_hit);
   assign w_word = bus.mem_ready ? bus.mem_data : ARB_TIMEOUT_DATA;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_timeout    <= 1'b0;
         r_data0      <= '0;
         r_data1      <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE && w_any_req) begin
            r_owner      <= w_winner;
            r_last_owner <= w_winner;
            r_addr       <= w_winner ? bus.addr1 : bus.addr0;
         end
         if (r_state == ST_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == ST_WAIT && !w_load) begin
            r_cnt <= w_cnt_inc;
         end
         if (w_load) begin
            if (r_owner) r_data1 <= w_word;
            else         r_data0 <= w_word;
            if (!bus.mem_ready) r_timeout <= 1'b1;
         end
      end
   end

   assign busy         = (r_state != ST_IDLE);
   assign timeout      = r_timeout;
   assign bus.gnt0     = busy && !r_owner;
   assign bus.gnt1     = busy && r_owner;
   assign bus.ready0   = (r_state == ST_RESPOND) && !r_owner;
   assign bus.ready1   = (r_state == ST_RESPOND) && r_owner;
   assign bus.mem_req  = (r_state == ST_ISSUE);
   assign bus.mem_addr = (r_state == ST_ISSUE) ? r_addr : 12'h000;
   assign bus.data0    = r_data0;
   assign bus.data1    = r_data1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority
// instance share one stimulus; table rows plus hand-written sequences.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, req1, mem_ready;
   logic [11:0] addr0, addr1;
   logic [15:0] mem_data;
   logic        busy_rr, tmo_rr, busy_fp, tmo_fp;

   int errors = 0;
   int checks = 0;

   mem_arbiter_if bus_rr ();
   mem_arbiter_if bus_fp ();

   assign bus_rr.req0 = req0;      assign bus_fp.req0 = req0;
   assign bus_rr.req1 = req1;      assign bus_fp.req1 = req1;
   assign bus_rr.addr0 = addr0;    assign bus_fp.addr0 = addr0;
   assign bus_rr.addr1 = addr1;    assign bus_fp.addr1 = addr1;
   assign bus_rr.mem_ready = mem_ready;  assign bus_fp.mem_ready = mem_ready;
   assign bus_rr.mem_data = mem_data;    assign bus_fp.mem_data = mem_data;

   mem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(0)) u_rr (
      .clk(clk), .rst(rst), .bus(bus_rr), .busy(busy_rr), .timeout(tmo_rr)
   );
   mem_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIORITY(1)) u_fp (
      .clk(clk), .rst(rst), .bus(bus_fp), .busy(busy_fp), .timeout(tmo_fp)
   );

   typedef struct packed {
      logic        g0, g1, y0, y1, mq;
      logic [11:0] ma;
      logic        b, t;
      logic [15:0] d0, d1;
   } out_t;

   typedef struct {
      logic        r0, r1;
      logic [11:0] a0, a1;
      logic        mr;
      logic [15:0] md;
      out_t        exp;
   } vec_t;

   out_t act_rr, act_fp;
   assign act_rr = {bus_rr.gnt0, bus_rr.gnt1, bus_rr.ready0, bus_rr.ready1, bus_rr.mem_req,
                    bus_rr.mem_addr, busy_rr, tmo_rr, bus_rr.data0, bus_rr.data1};
   assign act_fp = {bus_fp.gnt0, bus_fp.gnt1, bus_fp.ready0, bus_fp.ready1, bus_fp.mem_req,
                    bus_fp.mem_addr, busy_fp, tmo_fp, bus_fp.data0, bus_fp.data1};

   vec_t vq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r0, r1, input logic [11:0] a0, a1, input logic mr,
                      input logic [15:0] md, input logic g0, g1, y0, y1, mq,
                      input logic [11:0] ma, input logic b, t, input logic [15:0] d0, d1);
      vec_t v;
      v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.mr = mr; v.md = md;
      v.exp = {g0, g1, y0, y1, mq, ma, b, t, d0, d1};
      vq.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] ed_rr [2];
      logic [15:0] ed_fp [2];
      int          p;
      int          n;

      rst = 1'b0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; mem_ready = 0; mem_data = '0;
      repeat (3) tick();
      check("reset_rr", act_rr, 64'h0);
      check("reset_fp", act_fp, 64'h0);
      rst = 1'b1;
      tick();

      //   r0 r1 a0      a1      mr md        g0 g1 y0 y1 mq ma      b  t  d0        d1
      add(1, 0, 12'h005, 12'h000, 0, 16'h0000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h0000, 16'h0000);
      add(1, 0, 12'h005, 12'h000, 0, 16'h0000, 1, 0, 0, 0, 1, 12'h005, 1, 0, 16'h0000, 16'h0000);
      add(1, 0, 12'h005, 12'h000, 0, 16'h0000, 1, 0, 0, 0, 0, 12'h000, 1, 0, 16'h0000, 16'h0000);
      add(1, 0, 12'h005, 12'h000, 1, 16'h1234, 1, 0, 0, 0, 0, 12'h000, 1, 0, 16'h0000, 16'h0000);
      add(0, 0, 12'h000, 12'h000, 0, 16'h0000, 1, 0, 1, 0, 0, 12'h000, 1, 0, 16'h1234, 16'h0000);
      add(0, 0, 12'h000, 12'h000, 0, 16'h0000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h1234, 16'h0000);
      // Port 1 address changes after it has been latched.
      add(0, 1, 12'h000, 12'h010, 0, 16'h0000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h1234, 16'h0000);
      add(0, 1, 12'h000, 12'h020, 0, 16'h0000, 0, 1, 0, 0, 1, 12'h010, 1, 0, 16'h1234, 16'h0000);
      add(0, 1, 12'h000, 12'h020, 1, 16'hABCD, 0, 1, 0, 0, 0, 12'h000, 1, 0, 16'h1234, 16'h0000);
      add(0, 0, 12'h000, 12'h000, 0, 16'h0000, 0, 1, 0, 1, 0, 12'h000, 1, 0, 16'h1234, 16'hABCD);
      add(0, 0, 12'h000, 12'h000, 0, 16'h0000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h1234, 16'hABCD);
      // Stray mem_ready in ISSUE, req1 pulse during WAIT, stray mem_ready in IDLE.
      add(1, 0, 12'h0A5, 12'h000, 0, 16'h0000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h1234, 16'hABCD);
      add(1, 0, 12'h0A5, 12'h000, 1, 16'h0BAD, 1, 0, 0, 0, 1, 12'h0A5, 1, 0, 16'h1234, 16'hABCD);
      add(1, 1, 12'h0A5, 12'h000, 0, 16'h0000, 1, 0, 0, 0, 0, 12'h000, 1, 0, 16'h1234, 16'hABCD);
      add(1, 0, 12'h0A5, 12'h000, 0, 16'h0000, 1, 0, 0, 0, 0, 12'h000, 1, 0, 16'h1234, 16'hABCD);
      add(1, 0, 12'h0A5, 12'h000, 1, 16'h5A5A, 1, 0, 0, 0, 0, 12'h000, 1, 0, 16'h1234, 16'hABCD);
      add(0, 0, 12'h000, 12'h000, 0, 16'h0000, 1, 0, 1, 0, 0, 12'h000, 1, 0, 16'h5A5A, 16'hABCD);
      add(0, 0, 12'h000, 12'h000, 1, 16'hFFFF, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h5A5A, 16'hABCD);
      add(0, 0, 12'h000, 12'h000, 0, 16'h0000, 0, 0, 0, 0, 0, 12'h000, 0, 0, 16'h5A5A, 16'hABCD);

      foreach (vq[i]) begin
         req0 = vq[i].r0; req1 = vq[i].r1; addr0 = vq[i].a0; addr1 = vq[i].a1;
         mem_ready = vq[i].mr; mem_data = vq[i].md;
         #1;
         check($sformatf("vec%0d", i), act_rr, vq[i].exp);
         $display("vec %0d: req=%b%b mem_req=%b ready=%b%b", i, req1, req0,
                  bus_rr.mem_req, bus_rr.ready1, bus_rr.ready0);
         tick();
      end

      // Both ports held for four transactions.
      rst = 1'b0; tick(); rst = 1'b1; tick();
      ed_rr[0] = '0; ed_rr[1] = '0; ed_fp[0] = '0; ed_fp[1] = '0;
      req0 = 1; req1 = 1; addr0 = 12'h100; addr1 = 12'h200; mem_ready = 0;
      for (int t = 0; t < 4; t++) begin
         p = t % 2;
         tick();
         check($sformatf("rr_gnt%0d", t), {bus_rr.gnt1, bus_rr.gnt0, bus_rr.mem_addr},
               {(p == 1), (p == 0), (p == 1) ? 12'h200 : 12'h100});
         check($sformatf("fp_gnt%0d", t), {bus_fp.gnt1, bus_fp.gnt0, bus_fp.mem_addr},
               {1'b0, 1'b1, 12'h100});
         tick();
         mem_ready = 1; mem_data = 16'(16'h1000 + t);
         tick();
         mem_ready = 0;
         if (t == 3) begin req0 = 0; req1 = 0; end
         ed_rr[p] = 16'(16'h1000 + t);
         ed_fp[0] = 16'(16'h1000 + t);
         check($sformatf("rr_rdy%0d", t), {bus_rr.ready1, bus_rr.ready0, bus_rr.data0, bus_rr.data1},
               {(p == 1), (p == 0), ed_rr[0], ed_rr[1]});
         check($sformatf("fp_rdy%0d", t), {bus_fp.ready1, bus_fp.ready0, bus_fp.data0, bus_fp.data1},
               {1'b0, 1'b1, ed_fp[0], ed_fp[1]});
         $display("txn %0d: rr port %0d, fp port 0", t, p);
         tick();
      end

      // Memory never answers: abort after 8 WAIT cycles; requester drops req after grant.
      addr0 = 12'h777; req0 = 1;
      tick();
      req0 = 0;
      check("tmo_issue", {bus_rr.gnt0, bus_rr.mem_req, bus_rr.mem_addr, tmo_rr}, {1'b1, 1'b1, 12'h777, 1'b0});
      for (n = 1; n <= 20; n++) begin
         tick();
         if (bus_rr.ready0) break;
      end
      check("tmo_latency", 64'(n), 64'd9);
      check("tmo_resp_rr", {bus_rr.ready0, bus_rr.data0, tmo_rr}, {1'b1, 16'hCCCC, 1'b1});
      check("tmo_resp_fp", {bus_fp.ready0, bus_fp.data0, tmo_fp}, {1'b1, 16'hCCCC, 1'b1});
      tick();
      addr1 = 12'h333; req1 = 1;
      tick();
      check("post_tmo_issue", {bus_rr.gnt1, bus_rr.mem_addr, tmo_rr}, {1'b1, 12'h333, 1'b1});
      tick();
      mem_ready = 1; mem_data = 16'h4321;
      tick();
      mem_ready = 0; req1 = 0;
      check("post_tmo_resp", {bus_rr.ready1, bus_rr.data1, tmo_rr}, {1'b1, 16'h4321, 1'b1});
      tick();
      check("post_tmo_idle", {busy_rr, tmo_rr}, {1'b0, 1'b1});
      $display("timeout txn done: data0=%h timeout=%b", bus_rr.data0, tmo_rr);

      // Reset in WAIT, then a stale mem_ready after release.
      addr0 = 12'h0F0; req0 = 1;
      tick(); tick(); tick();
      check("pre_rst_wait", {busy_rr, bus_rr.gnt0, bus_rr.mem_req}, {1'b1, 1'b1, 1'b0});
      rst = 1'b0; req0 = 0;
      #1;
      check("rst_async_rr", act_rr, 64'h0);
      check("rst_async_fp", act_fp, 64'h0);
      tick(); tick();
      rst = 1'b1; mem_ready = 1; mem_data = 16'hDEAD;
      tick();
      mem_ready = 0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("post_rst%0d", k), act_rr, 64'h0);
         tick();
      end
      $display("reset txn done: busy=%b", busy_rr);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
